// File: rtl/mem_req_arbiter.sv
// Shares one single-port RAM between NUM_CH level-held requesters.
// Selectable fixed-priority or round-robin grant; one ready pulse per access.
module mem_req_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RAM_LAT  = 1,
    parameter int ARB_MODE = 1
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [NUM_CH-1:0]          req_ren,
    input  logic [NUM_CH-1:0]          req_wen,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          req_ready,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wdata,
    output logic                       ram_ren,
    output logic                       ram_wen,
    input  logic [DATA_W-1:0]          ram_rdata,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(RAM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RAM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    grant_r, grant_s;
    logic [IDX_W-1:0]    ptr_r, ptr_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [NUM_CH-1:0]   ready_r, ready_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                ren_r, ren_s;
    logic                wen_r, wen_s;
    logic                busy_r, busy_s;

    logic [NUM_CH-1:0]   reqs_s;
    logic [IDX_W:0]      sum_s;
    logic [IDX_W-1:0]    cand_s;
    logic [IDX_W-1:0]    pick_s;
    logic                found_s;

    // Arbitration: first requester scanning upward from 0 or from the RR pointer
    always_comb begin
        reqs_s  = req_ren | req_wen;
        sum_s   = '0;
        cand_s  = '0;
        pick_s  = '0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == 1) begin
                sum_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
                if (sum_s >= (IDX_W+1)'(NUM_CH)) begin
                    sum_s = sum_s - (IDX_W+1)'(NUM_CH);
                end else begin
                    sum_s = sum_s;
                end
            end else begin
                sum_s = (IDX_W+1)'(k);
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!found_s && reqs_s[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-register values for the IDLE/ACCESS/DONE sequence
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        ready_s = '0;
        rdata_s = rdata_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        ren_s   = ren_r;
        wen_s   = wen_r;
        busy_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_s = pick_s;
                    addr_s  = req_addr[pick_s*ADDR_W +: ADDR_W];
                    wdata_s = req_wdata[pick_s*DATA_W +: DATA_W];
                    // a write wins when both strobes are set
                    wen_s   = req_wen[pick_s];
                    ren_s   = req_ren[pick_s] & ~req_wen[pick_s];
                    cnt_s   = CNT_INIT;
                    busy_s  = 1'b1;
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = ACCESS;
                end else begin
                    if (ren_r) begin
                        rdata_s = ram_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    ren_s            = 1'b0;
                    wen_s            = 1'b0;
                    ready_s[grant_r] = 1'b1;
                    state_s          = DONE;
                end
            end
            DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
                if (ARB_MODE == 1) begin
                    if (grant_r == IDX_W'(NUM_CH - 1)) begin
                        ptr_s = '0;
                    end else begin
                        ptr_s = grant_r + IDX_W'(1);
                    end
                end else begin
                    ptr_s = ptr_r;
                end
            end
            default: begin
                ren_s   = 1'b0;
                wen_s   = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            grant_r <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
            ready_r <= '0;
            rdata_r <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            ren_r   <= 1'b0;
            wen_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            ready_r <= ready_s;
            rdata_r <= rdata_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            ren_r   <= ren_s;
            wen_r   <= wen_s;
            busy_r  <= busy_s;
        end
    end

    assign req_ready = ready_r;
    assign req_rdata = rdata_r;
    assign ram_addr  = addr_r;
    assign ram_wdata = wdata_r;
    assign ram_ren   = ren_r;
    assign ram_wen   = wen_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: dut_a is 3-channel round robin (RAM_LAT=2),
// dut_b is 2-channel fixed priority (RAM_LAT=1); each has a small RAM model.
module tb_mem_req_arbiter;

    typedef struct packed {
        logic [2:0]  rdy;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_load;

    logic [2:0]  ren_a, wen_a, ready_a;
    logic [95:0] addr_a, wdata_a;
    logic [31:0] rdata_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
    logic        ram_ren_a, ram_wen_a, busy_a;

    logic [1:0]  ren_b, wen_b, ready_b;
    logic [63:0] addr_b, wdata_b;
    logic [31:0] rdata_b, ram_addr_b, ram_wdata_b, ram_rdata_b;
    logic        ram_ren_b, ram_wen_b, busy_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RAM_LAT(2), .ARB_MODE(1)) dut_a (
        .clk(clk), .nRST(rst), .req_ren(ren_a), .req_wen(wen_a), .req_addr(addr_a),
        .req_wdata(wdata_a), .req_ready(ready_a), .req_rdata(rdata_a), .ram_addr(ram_addr_a),
        .ram_wdata(ram_wdata_a), .ram_ren(ram_ren_a), .ram_wen(ram_wen_a),
        .ram_rdata(ram_rdata_a), .busy(busy_a)
    );

    mem_req_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .ARB_MODE(0)) dut_b (
        .clk(clk), .nRST(rst), .req_ren(ren_b), .req_wen(wen_b), .req_addr(addr_b),
        .req_wdata(wdata_b), .req_ready(ready_b), .req_rdata(rdata_b), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_ren(ram_ren_b), .ram_wen(ram_wen_b),
        .ram_rdata(ram_rdata_b), .busy(busy_b)
    );

    // RAM models: unwritten word at byte address X reads as 0x0BAD0000 | X
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'h0BAD_0000 | (32'(i) << 2);
                mem_b[i] <= 32'h0BAD_0000 | (32'(i) << 2);
            end
            mem_a[64] <= 32'hDEAD_BEEF;
        end else begin
            if (ram_wen_a) mem_a[ram_addr_a[9:2]] <= ram_wdata_a;
            if (ram_wen_b) mem_b[ram_addr_b[9:2]] <= ram_wdata_b;
        end
    end
    assign ram_rdata_a = mem_a[ram_addr_a[9:2]];
    assign ram_rdata_b = mem_b[ram_addr_b[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic wait_ready(input int which, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if ((which == 0 && ready_a != 3'b000) || (which == 1 && ready_b != 2'b00)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ready pulse within 20 cycles", name);
        end
    endtask

    // Monitor for dut_a: every ready pulse must match the next scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ready_a != 3'b000) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_ready", {29'd0, ready_a}, 32'd0);
            end else begin
                e = q_a.pop_front();
                chk("a_ready", {29'd0, ready_a}, {29'd0, e.rdy});
                chk("a_rdata", rdata_a, e.dat);
            end
        end
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ready_b != 2'b00) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_ready", {30'd0, ready_b}, 32'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_ready", {29'd0, 1'b0, ready_b}, {29'd0, e.rdy});
                chk("b_rdata", rdata_b, e.dat);
            end
        end
    end

    initial begin
        int last;
        rst = 1'b1; mem_load = 1'b1;
        ren_a = 3'b000; wen_a = 3'b000; addr_a = '0; wdata_a = '0;
        ren_b = 2'b00;  wen_b = 2'b00;  addr_b = '0; wdata_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mem_load = 1'b0;

        chk("rst_ready_a", {29'd0, ready_a}, 32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_strobes_a", {30'd0, ram_ren_a, ram_wen_a}, 32'd0);
        chk("rst_ram_addr_a", ram_addr_a, 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_ready_b", {30'd0, ready_b}, 32'd0);

        // Single read: ch0 reads 0x100
        ren_a[0] = 1'b1; addr_a[0 +: 32] = 32'h0000_0100;
        q_a.push_back('{3'b001, 32'hDEAD_BEEF});
        cyc();
        chk("rd_c1_ren", {31'd0, ram_ren_a}, 32'd1);
        chk("rd_c1_addr", ram_addr_a, 32'h0000_0100);
        chk("rd_c1_busy", {31'd0, busy_a}, 32'd1);
        cyc();
        chk("rd_c2_ren", {31'd0, ram_ren_a}, 32'd1);
        chk("rd_c2_ready", {29'd0, ready_a}, 32'd0);
        cyc();
        chk("rd_c3_ready", {29'd0, ready_a}, 32'd1);
        chk("rd_c3_ren", {31'd0, ram_ren_a}, 32'd0);
        ren_a = 3'b000;
        cyc();
        chk("rd_c4_busy", {31'd0, busy_a}, 32'd0);

        // ren and wen together on ch0: a write, rdata keeps the old value
        ren_a[0] = 1'b1; wen_a[0] = 1'b1;
        addr_a[0 +: 32] = 32'h0000_0080; wdata_a[0 +: 32] = 32'h1111_2222;
        q_a.push_back('{3'b001, 32'hDEAD_BEEF});
        cyc();
        chk("both_wen", {31'd0, ram_wen_a}, 32'd1);
        chk("both_ren", {31'd0, ram_ren_a}, 32'd0);
        chk("both_wdata", ram_wdata_a, 32'h1111_2222);
        chk("both_addr", ram_addr_a, 32'h0000_0080);
        cyc();
        cyc();
        chk("both_ready", {29'd0, ready_a}, 32'd1);
        ren_a = 3'b000; wen_a = 3'b000;
        cyc();

        // Reset in the second ACCESS cycle of a ch2 read
        ren_a[2] = 1'b1; addr_a[64 +: 32] = 32'h0000_0200;
        cyc();
        chk("rstmid_c1_ren", {31'd0, ram_ren_a}, 32'd1);
        cyc();
        chk("rstmid_c2_ren", {31'd0, ram_ren_a}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_ren_drop", {31'd0, ram_ren_a}, 32'd0);
        chk("rstmid_busy", {31'd0, busy_a}, 32'd0);
        chk("rstmid_rdata", rdata_a, 32'd0);
        ren_a = 3'b000;
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        chk("rstmid_idle_busy", {31'd0, busy_a}, 32'd0);

        // Round robin: all three hold reads; order 0,1,2,0 from a reset pointer
        ren_a = 3'b111;
        addr_a[0 +: 32] = 32'h0000_0080;
        addr_a[32 +: 32] = 32'h0000_0100;
        addr_a[64 +: 32] = 32'h0000_0200;
        q_a.push_back('{3'b001, 32'h1111_2222});
        q_a.push_back('{3'b010, 32'hDEAD_BEEF});
        q_a.push_back('{3'b100, 32'h0BAD_0200});
        q_a.push_back('{3'b001, 32'h1111_2222});
        last = cyc_n;
        wait_ready(0, "rr_first");
        chk("rr_first_latency", 32'(cyc_n - last), 32'd3);
        for (int p = 1; p < 4; p++) begin
            last = cyc_n;
            wait_ready(0, "rr_next");
            chk("rr_interval", 32'(cyc_n - last), 32'd4);
        end
        ren_a = 3'b000;
        repeat (2) cyc();

        // Write on dut_b (RAM_LAT=1): ch1 writes 0xCAFEF00D to 0x40
        wen_b[1] = 1'b1; addr_b[32 +: 32] = 32'h0000_0040; wdata_b[32 +: 32] = 32'hCAFE_F00D;
        q_b.push_back('{3'b010, 32'h0000_0000});
        cyc();
        chk("wr_wen", {31'd0, ram_wen_b}, 32'd1);
        chk("wr_addr", ram_addr_b, 32'h0000_0040);
        chk("wr_wdata", ram_wdata_b, 32'hCAFE_F00D);
        cyc();
        chk("wr_ready", {30'd0, ready_b}, 32'd2);
        wen_b = 2'b00;
        cyc();

        // Fixed priority: ch0 keeps requesting, ch1 waits until ch0 drops
        ren_b = 2'b11;
        addr_b[0 +: 32] = 32'h0000_0040;
        addr_b[32 +: 32] = 32'h0000_000C;
        for (int p = 0; p < 3; p++) q_b.push_back('{3'b001, 32'hCAFE_F00D});
        q_b.push_back('{3'b010, 32'h0BAD_000C});
        for (int p = 0; p < 3; p++) begin
            wait_ready(1, "fp_ch0");
            chk("fp_ch0_ready", {30'd0, ready_b}, 32'd1);
        end
        ren_b = 2'b10;
        last = cyc_n;
        wait_ready(1, "fp_ch1");
        chk("fp_ch1_ready", {30'd0, ready_b}, 32'd2);
        chk("fp_ch1_latency", 32'(cyc_n - last), 32'd3);
        ren_b = 2'b00;

        repeat (4) cyc();
        chk("a_queue_empty", 32'(q_a.size()), 32'd0);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised memory request arbiter that lets NUM_CH requesters share one single-port RAM. Typical requesters are instruction fetch, data load/store, and a debug/DMA port. Each channel issues a level-held read or write and receives a one-cycle ready pulse when the access completes. It replaces the fixed two-path instruction/data split in the core top and supports multi-cycle RAM latency and selectable arbitration.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RAM_LAT, 1, RAM access cycles (≥1); read data is valid on ram_rdata during the last access cycle
- ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round robin

Ports:
- clk  in  1  clock; all state changes on rising edge
- nRST  in  1  reset; asynchronous, active-high (asserted = 1)
- req_ren  in  NUM_CH  per-channel read request, held until ready
- req_wen  in  NUM_CH  per-channel write request, held until ready
- req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  packed write data, same packing as req_addr
- req_ready  out  NUM_CH  one-hot completion pulse to the granted channel
- req_rdata  out  DATA_W  read data, shared by all channels; valid when req_ready[i]=1 for a read
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high in ACCESS and DONE

## Operation
- **Request rules.** Channel i is requesting when req_ren[i] | req_wen[i]. If both are set, the access is a write; the read is ignored.
- **States:** IDLE, ACCESS, DONE.
- **IDLE**
  - With no requests, stay in IDLE.
  - Otherwise, select a grant per ARB_MODE.
  - Register the granted channel's address, wdata, and op into ram_addr, ram_wdata, and ram_ren/ram_wen.
  - Load the latency counter with RAM_LAT-1 and go to ACCESS.
- **ACCESS**
  - ram_ren or ram_wen is held high.
  - When the counter is nonzero, decrement it and stay.
  - When the counter is 0: on a read, capture ram_rdata into req_rdata; deassert the strobes and go to DONE.
- **DONE**
  - req_ready[grant]=1 for exactly this cycle.
  - req_rdata holds its value until the next read capture.
  - In round-robin mode, set the priority pointer to (grant+1) mod NUM_CH.
  - Go to IDLE.
- **Fixed priority.** The lowest-index requesting channel wins.
- **Round robin.** The first requesting channel at or after the pointer, scanning with wrap-around, wins.
  - The pointer changes only in DONE.
  - With a single requester, that channel wins regardless of the pointer.
- **Request changes during a transaction.** Changes to req_* after the grant are ignored until the next IDLE, because the address, data, and op are latched.
- **Requester obligation.** A requester must drop or change its request on the edge that ends its DONE cycle. If it keeps holding, it is rearbitrated as a new request.
- **Reset values.** State IDLE, pointer 0, req_ready 0, req_rdata 0, ram_addr 0, ram_wdata 0, ram_ren 0, ram_wen 0, busy 0.
- **Reset mid-transaction.** Asserting nRST during ACCESS or DONE aborts immediately and asynchronously: strobes drop and no ready pulse is issued.

## Timing
- A request sampled in IDLE at cycle 0 gives ACCESS in cycles 1..RAM_LAT and DONE (ready pulse) in cycle RAM_LAT+1.
- Per-transaction occupancy is RAM_LAT+2 cycles. Back-to-back grants are separated by one IDLE cycle.
- Worst-case wait for a round-robin requester is (NUM_CH-1)*(RAM_LAT+2) cycles after its first IDLE sample. Fixed priority has no bound.
- req_ready is a registered decode of state, with no combinational path from req_* to req_ready or ram_*.
- RAM_LAT=1: ACCESS lasts one cycle and ram_rdata is captured at the end of that cycle.
- Counter width is clog2(RAM_LAT)+1 bits. The counter never wraps below 0.

## Test plan
- **Single read.** NUM_CH=2, RAM_LAT=2, ch0 reads 0x100, RAM returns 0xDEADBEEF.
  - Expect ram_ren high in cycles 1–2 with ram_addr=0x100.
  - Expect req_ready=2'b01 in cycle 3 with req_rdata=0xDEADBEEF.
- **Write.** ch1 writes 0xCAFEF00D to 0x40, RAM_LAT=1.
  - Expect ram_wen high in cycle 1 with ram_addr=0x40 and ram_wdata=0xCAFEF00D.
  - Expect req_ready=2'b10 in cycle 2.
- **Round robin.** NUM_CH=3, ARB_MODE=1, all three channels hold reads continuously.
  - Expect grant order 0,1,2,0.
  - Expect ready pulses every RAM_LAT+2 cycles.
- **Fixed priority.** ARB_MODE=0, ch0 and ch1 both hold requests and ch0 re-requests every time.
  - Expect ch1 never granted while ch0 requests.
  - Expect ch1 granted in the first IDLE after ch0 drops.
- **Reset mid-transaction.** Assert nRST in the second ACCESS cycle with RAM_LAT=3.
  - Expect ram_ren=0 immediately, no req_ready pulse, pointer=0, and state IDLE after release.
- **ren and wen both set.** ch0 asserts req_ren and req_wen together.
  - Expect ram_wen=1, ram_ren=0, and req_rdata unchanged at ready.
